ldst_access_arbiter: RTL

//  Shares one data-memory access port between NUM_REQ ldst_unit instances.

---
 rtl/ldst_access_arbiter_if.sv | 30 +++
 rtl/ldst_access_arbiter.sv | 152 +++++++++++++++
 2 files changed

// File: rtl/ldst_access_arbiter_if.sv
// Request/grant/beat bundle between the ldst_units and the access arbiter.
// The arbiter takes the slave side; the ldst_units and memory port take the master side.
interface ldst_access_arbiter_if #(
    parameter int NUM_REQ   = 2,
    parameter int ADDR_W    = 32,
    parameter int WIDTH_REQ = $clog2(NUM_REQ)
);
    logic                             I_Stall;
    logic [NUM_REQ-1:0]               I_Req;
    logic [NUM_REQ-1:0][ADDR_W-1:0]   I_Length;
    logic [NUM_REQ-1:0][ADDR_W-1:0]   I_Stride;
    logic [NUM_REQ-1:0][ADDR_W-1:0]   I_Base;
    logic [NUM_REQ-1:0]               O_Access_Grant;
    logic [NUM_REQ-1:0]               O_Term;
    logic                             I_Ready;
    logic                             O_Req;
    logic [ADDR_W-1:0]                O_Addr;
    logic [WIDTH_REQ-1:0]             O_Owner;
    logic                             O_Busy;

    modport slave (
        input  I_Stall, I_Req, I_Length, I_Stride, I_Base, I_Ready,
        output O_Access_Grant, O_Term, O_Req, O_Addr, O_Owner, O_Busy
    );

    modport master (
        output I_Stall, I_Req, I_Length, I_Stride, I_Base, I_Ready,
        input  O_Access_Grant, O_Term, O_Req, O_Addr, O_Owner, O_Busy
    );
endinterface

// File: rtl/ldst_access_arbiter.sv
// Arbitrates one memory port among NUM_REQ ldst_units and sequences a strided burst (LDST_ARB_FIXED_PRIO_EN: fixed priority).
// Latency: grant 1 cycle after request in IDLE, first beat 2 cycles after; Length=N takes N+3 cycles.
// Backpressure: one beat per I_Ready cycle, address held while I_Ready=0; I_Stall freezes all state and masks outputs.
module ldst_access_arbiter #(
    parameter int NUM_REQ   = 2,
    parameter int ADDR_W    = 32,
    parameter int WIDTH_REQ = $clog2(NUM_REQ)
) (
    input  logic                   clock,
    input  logic                   reset,
    ldst_access_arbiter_if.slave   bus
);
    typedef logic [ADDR_W-1:0] address_t;
    typedef enum logic [1:0] {S_IDLE, S_GRANT, S_RUN, S_TERM} state_t;

    state_t               r_state, w_state_nxt;
    logic [WIDTH_REQ-1:0] r_owner, w_owner_nxt;
    address_t             r_base, w_base_nxt;
    address_t             r_stride, w_stride_nxt;
    address_t             r_len, w_len_nxt;
    address_t             r_addr, w_addr_nxt;
    address_t             r_cnt, w_cnt_nxt;
    address_t             w_cnt_inc;

    logic                 w_found;
    logic [WIDTH_REQ-1:0] w_pick;
    logic [WIDTH_REQ-1:0] w_rr_start;
    logic [WIDTH_REQ-1:0] w_idx_n;
    int                   w_idx;

`ifdef LDST_ARB_FIXED_PRIO_EN
    assign w_rr_start = '0;
`else
    logic [WIDTH_REQ-1:0] r_rr_ptr;
    logic [WIDTH_REQ-1:0] w_owner_inc;

    assign w_rr_start  = r_rr_ptr;
    assign w_owner_inc = (int'(r_owner) == NUM_REQ - 1) ? '0 : r_owner + WIDTH_REQ'(1);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_rr_ptr <= '0;
        end else if (!bus.I_Stall && r_state == S_TERM) begin
            r_rr_ptr <= w_owner_inc;
        end
    end
`endif

    assign w_cnt_inc = r_cnt + address_t'(1);

    // First pending request at or after the start pointer, wrapping around.
    always_comb begin
        w_found = 1'b0;
        w_pick  = '0;
        w_idx   = 0;
        w_idx_n = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            w_idx = int'(w_rr_start) + i;
            if (w_idx >= NUM_REQ) begin
                w_idx = w_idx - NUM_REQ;
            end
            w_idx_n = WIDTH_REQ'(w_idx);
            if (!w_found && bus.I_Req[w_idx_n]) begin
                w_found = 1'b1;
                w_pick  = w_idx_n;
            end
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_owner_nxt  = r_owner;
        w_base_nxt   = r_base;
        w_stride_nxt = r_stride;
        w_len_nxt    = r_len;
        w_addr_nxt   = r_addr;
        w_cnt_nxt    = r_cnt;
        case (r_state)
            S_IDLE: begin
                if (w_found) begin
                    w_owner_nxt  = w_pick;
                    w_base_nxt   = bus.I_Base[w_pick];
                    w_stride_nxt = bus.I_Stride[w_pick];
                    w_len_nxt    = bus.I_Length[w_pick];
                    w_state_nxt  = S_GRANT;
                end
            end
            S_GRANT: begin
                w_addr_nxt  = r_base;
                w_cnt_nxt   = '0;
                w_state_nxt = (r_len == '0) ? S_TERM : S_RUN;
            end
            S_RUN: begin
                if (bus.I_Ready) begin
                    w_addr_nxt = r_addr + r_stride;
                    w_cnt_nxt  = w_cnt_inc;
                    if (w_cnt_inc == r_len) begin
                        w_state_nxt = S_TERM;
                    end
                end
            end
            S_TERM: begin
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state  <= S_IDLE;
            r_owner  <= '0;
            r_base   <= '0;
            r_stride <= '0;
            r_len    <= '0;
            r_addr   <= '0;
            r_cnt    <= '0;
        end else if (!bus.I_Stall) begin
            r_state  <= w_state_nxt;
            r_owner  <= w_owner_nxt;
            r_base   <= w_base_nxt;
            r_stride <= w_stride_nxt;
            r_len    <= w_len_nxt;
            r_addr   <= w_addr_nxt;
            r_cnt    <= w_cnt_nxt;
        end
    end

    // Pulses are masked while stalled; the frozen state re-presents them on release.
    always_comb begin
        bus.O_Access_Grant = '0;
        bus.O_Term         = '0;
        bus.O_Req          = 1'b0;
        bus.O_Addr         = '0;
        if (r_state == S_RUN) begin
            bus.O_Addr = r_addr;
        end
        if (!bus.I_Stall) begin
            case (r_state)
                S_GRANT: bus.O_Access_Grant[r_owner] = 1'b1;
                S_RUN:   bus.O_Req                   = 1'b1;
                S_TERM:  bus.O_Term[r_owner]         = 1'b1;
                default: ;
            endcase
        end
    end

    assign bus.O_Owner = r_owner;
    assign bus.O_Busy  = (r_state != S_IDLE);
endmodule
